bmp_line_feeder: RTL and testbench

//  Upstream stage of the 3x3 edge-detection pipeline. Consumes a raw BMP byte stream and forwards the

---
 rtl/bmp_line_feeder_pkg.sv | 23 ++
 rtl/bmp_line_feeder_if.sv | 25 ++
 rtl/bmp_line_feeder_irq_req_tracker.sv | 44 ++++
 rtl/bmp_line_feeder.sv | 175 +++++++++++++++++
 tb/tb_bmp_line_feeder.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmp_line_feeder_pkg.sv
// Shared definitions for the image-processing pipeline: feeder state encoding,
// counter width helper and the pixel width default shared with the kernel wrapper.
package img_proc_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PRIME,
      WAIT,
      LINE,
      PWAIT,
      PAD,
      DONE
   } feederState_t;

   // Width of a counter that only ever has to hold 0..n-1.
   function automatic int cntWidth(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bmp_line_feeder_if.sv
// Byte-stream and output bundle of the BMP line feeder: upstream bytes in,
// header bytes to the file writer and pixels to the kernel wrapper out.
interface bmp_line_feeder_if #(
   parameter int DATA_WIDTH = img_proc_pkg::DEFAULT_DATA_WIDTH
);

   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] hdr_data;
   logic                  hdr_valid;
   logic [DATA_WIDTH-1:0] inPixel;
   logic                  inPixelValid;

   modport master (
      output s_data, s_valid,
      input  s_ready, hdr_data, hdr_valid, inPixel, inPixelValid
   );

   modport slave (
      input  s_data, s_valid,
      output s_ready, hdr_data, hdr_valid, inPixel, inPixelValid
   );

endinterface

// File: rtl/bmp_line_feeder_irq_req_tracker.sv
// Turns the kernel's "line buffer free" level into one-line requests: rising-edge
// detect, a single pending request flag, and a sticky overrun flag for dropped requests.
module irq_req_tracker (
   input  logic clk,
   input  logic rst,
   input  logic interrupt,
   input  logic consume,
   input  logic arm,
   input  logic clear,
   output logic pending,
   output logic overrun
);

   logic r_irqQ;
   logic r_pending;
   logic r_overrun;
   logic w_edge;

   assign w_edge = interrupt & ~r_irqQ & arm;

   // A new edge in the same cycle as a consumption re-arms the request; an edge
   // arriving while one is still outstanding is dropped and remembered as overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irqQ    <= 1'b0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_irqQ <= interrupt;
         if (w_edge)
            r_pending <= 1'b1;
         else if (consume)
            r_pending <= 1'b0;
         if (clear)
            r_overrun <= 1'b0;
         else if (w_edge && r_pending && !consume)
            r_overrun <= 1'b1;
      end
   end

   assign pending = r_pending;
   assign overrun = r_overrun;

endmodule

// File: rtl/bmp_line_feeder.sv
// Feeds a raw BMP byte stream into the 3x3 kernel: header bytes to the writer, then
// pixel lines paced by kernel interrupts, then zero pad lines. FEEDER_STALL_CNT_EN adds stall_cnt.
module bmp_line_feeder
   import img_proc_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int IMG_WIDTH   = 512,
   parameter int IMG_HEIGHT  = 512,
   parameter int IMG_HEADER  = 1080,
   parameter int PRIME_LINES = 4,
   parameter int PAD_LINES   = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_start,
   bmp_line_feeder_if.slave bus,
   input  logic interrupt,
   output logic busy,
   output logic done,
   output logic irq_overrun
`ifdef FEEDER_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int BYTE_W = cntWidth(IMG_HEADER);
   localparam int PIX_W  = cntWidth(IMG_WIDTH);
   localparam int LINE_W = cntWidth(IMG_HEIGHT + PAD_LINES + 1);

   localparam logic [BYTE_W-1:0] HDR_LAST   = BYTE_W'(IMG_HEADER - 1);
   localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(IMG_WIDTH - 1);
   localparam logic [LINE_W-1:0] PRIME_LAST = LINE_W'(PRIME_LINES - 1);
   localparam logic [LINE_W-1:0] IMG_LAST   = LINE_W'(IMG_HEIGHT - 1);
   localparam logic [LINE_W-1:0] PAD_LAST   = LINE_W'(IMG_HEIGHT + PAD_LINES - 1);
   localparam feederState_t AFTER_IMG = (PAD_LINES == 0) ? DONE : PWAIT;

   feederState_t r_state;
   feederState_t w_next;

   logic [BYTE_W-1:0]     r_byteCnt;
   logic [PIX_W-1:0]      r_pixCnt;
   logic [LINE_W-1:0]     r_lineCnt;
   logic [DATA_WIDTH-1:0] r_hdrData;
   logic                  r_hdrValid;
   logic [DATA_WIDTH-1:0] r_pixData;
   logic                  r_pixValid;
   logic                  r_busy;
   logic                  r_done;

   logic w_sReady, w_accept, w_pixBeat, w_consume, w_pending, w_arm, w_clear;
   logic w_hdrLast, w_pixLast;

   assign w_sReady  = (r_state == HDR) || (r_state == PRIME) || (r_state == LINE);
   assign w_accept  = bus.s_valid && w_sReady;
   assign w_pixBeat = (r_state == PAD) ||
                      (w_accept && ((r_state == PRIME) || (r_state == LINE)));
   assign w_hdrLast = (r_byteCnt == HDR_LAST);
   assign w_pixLast = (r_pixCnt == PIX_LAST);
   assign w_arm     = (r_state == WAIT) || (r_state == LINE) ||
                      (r_state == PWAIT) || (r_state == PAD);
   assign w_clear   = (r_state == IDLE) && frame_start;

   irq_req_tracker u_irq (
      .clk       (clk),
      .rst       (rst),
      .interrupt (interrupt),
      .consume   (w_consume),
      .arm       (w_arm),
      .clear     (w_clear),
      .pending   (w_pending),
      .overrun   (irq_overrun)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Leaving WAIT/PWAIT is what consumes a request, so consume is tied to that transition.
   always_comb begin
      w_next    = r_state;
      w_consume = 1'b0;
      case (r_state)
         IDLE:  if (frame_start) w_next = HDR;
         HDR:   if (w_accept && w_hdrLast) w_next = PRIME;
         PRIME: if (w_accept && w_pixLast && (r_lineCnt == PRIME_LAST))
                   w_next = (IMG_HEIGHT == PRIME_LINES) ? AFTER_IMG : WAIT;
         WAIT:  if (w_pending) begin
                   w_next    = LINE;
                   w_consume = 1'b1;
                end
         LINE:  if (w_accept && w_pixLast)
                   w_next = (r_lineCnt == IMG_LAST) ? AFTER_IMG : WAIT;
         PWAIT: if (w_pending) begin
                   w_next    = PAD;
                   w_consume = 1'b1;
                end
         PAD:   if (w_pixLast) w_next = (r_lineCnt == PAD_LAST) ? DONE : PWAIT;
         DONE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Line count runs continuously over image and pad lines so one compare ends each phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byteCnt <= '0;
         r_pixCnt  <= '0;
         r_lineCnt <= '0;
      end else begin
         if (r_state != HDR)
            r_byteCnt <= '0;
         else if (w_accept)
            r_byteCnt <= w_hdrLast ? '0 : r_byteCnt + 1'b1;

         if ((r_state != PRIME) && (r_state != LINE) && (r_state != PAD))
            r_pixCnt <= '0;
         else if (w_pixBeat)
            r_pixCnt <= w_pixLast ? '0 : r_pixCnt + 1'b1;

         if (r_state == IDLE)
            r_lineCnt <= '0;
         else if (w_pixBeat && w_pixLast)
            r_lineCnt <= r_lineCnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hdrData  <= '0;
         r_hdrValid <= 1'b0;
         r_pixData  <= '0;
         r_pixValid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_hdrValid <= w_accept && (r_state == HDR);
         if (w_accept && (r_state == HDR))
            r_hdrData <= bus.s_data;
         r_pixValid <= w_pixBeat;
         if (w_pixBeat)
            r_pixData <= (r_state == PAD) ? '0 : bus.s_data;
         r_busy <= (w_next != IDLE);
         r_done <= (w_next == DONE);
      end
   end

`ifdef FEEDER_STALL_CNT_EN
   logic [31:0] r_stallCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stallCnt <= '0;
      else if (w_clear)
         r_stallCnt <= '0;
      else if (((r_state == PRIME) || (r_state == LINE)) && !bus.s_valid &&
               (r_stallCnt != 32'hFFFF_FFFF))
         r_stallCnt <= r_stallCnt + 32'd1;
   end

   assign stall_cnt = r_stallCnt;
`endif

   assign bus.s_ready      = w_sReady;
   assign bus.hdr_data     = r_hdrData;
   assign bus.hdr_valid    = r_hdrValid;
   assign bus.inPixel      = r_pixData;
   assign bus.inPixelValid = r_pixValid;
   assign busy             = r_busy;
   assign done             = r_done;

endmodule

// File: tb/tb_bmp_line_feeder.sv
// Self-checking bench for bmp_line_feeder with a small 8x6 image: scoreboard of header
// bytes and pixels filled as the source hands bytes over, drained as the DUT emits them.
module tb_bmp_line_feeder;

   localparam int DW        = 8;
   localparam int W         = 8;
   localparam int H         = 6;
   localparam int HB        = 4;
   localparam int P         = 4;
   localparam int PADL      = 2;
   localparam int IMG_BYTES = HB + H * W;
   localparam int PIX_TOTAL = (H + PADL) * W;

   logic clk = 1'b0;
   logic rst, frame_start, interrupt, busy, done, irq_overrun;
`ifdef FEEDER_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   bmp_line_feeder_if #(.DATA_WIDTH(DW)) bus ();

   bmp_line_feeder #(
      .DATA_WIDTH (DW),
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .IMG_HEADER (HB),
      .PRIME_LINES(P),
      .PAD_LINES  (PADL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .bus        (bus),
      .interrupt  (interrupt),
      .busy       (busy),
      .done       (done),
      .irq_overrun(irq_overrun)
`ifdef FEEDER_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int cycle = 0;
   int srcIdx, doneCount, stallInj, stallPct, mode;
   logic [7:0] expHdr[$], expPix[$], gotHdr[$], gotPix[$];
   int pixCyc[$];
   int irqAt[$];

   function automatic logic [7:0] srcByte(input int i);
      return 8'((i * 37 + 11) & 255);
   endfunction

   // Which completed-line counts schedule a delayed interrupt pulse in each scenario mode.
   function automatic bit irqWanted(input int n);
      case (mode)
         1:       return (n == P * W) || (n > H * W);
         2:       return (n == P * W);
         default: return 1'b1;
      endcase
   endfunction

   // One clock of stimulus: sample outputs, then drive source, interrupt and frame_start.
   task automatic applyStimulus();
      bit v;
      int p;
      @(negedge clk);
      cycle++;
      if (bus.hdr_valid) gotHdr.push_back(bus.hdr_data);
      if (bus.inPixelValid) begin
         gotPix.push_back(bus.inPixel);
         pixCyc.push_back(cycle);
         if ((gotPix.size() % W == 0) && (gotPix.size() >= P * W) &&
             (gotPix.size() < PIX_TOTAL) && irqWanted(gotPix.size()))
            irqAt.push_back(cycle + 10);
      end
      if (done) doneCount++;
      interrupt   = 1'b0;
      frame_start = 1'b0;
      if (irqAt.size() > 0 && irqAt[0] == cycle) begin
         void'(irqAt.pop_front());
         interrupt = 1'b1;
      end
      if (srcIdx < IMG_BYTES) begin
         v = ($urandom_range(99) >= stallPct);
         bus.s_valid = v;
         bus.s_data  = srcByte(srcIdx);
         if (bus.s_ready && !v && srcIdx >= HB) stallInj++;
         if (v && bus.s_ready) begin
            p = srcIdx - HB;
            if (srcIdx < HB) expHdr.push_back(srcByte(srcIdx));
            else             expPix.push_back(srcByte(srcIdx));
            if (mode == 1 && p >= P * W && p % W == W - 1) interrupt = 1'b1;
            if (mode == 2 && (p == P * W + 1 || p == P * W + 4)) interrupt = 1'b1;
            srcIdx++;
            if (srcIdx == IMG_BYTES) repeat (PADL * W) expPix.push_back(8'h00);
         end
      end else begin
         bus.s_valid = 1'b0;
         bus.s_data  = '0;
      end
      if (mode == 3 && srcIdx > 0 && srcIdx < HB + P * W - 4) begin
         if (cycle % 5 == 0) frame_start = 1'b1;
         if (cycle % 3 == 0) interrupt = 1'b1;
      end
   endtask

   task automatic startFrame(input int m, input int pct);
      expHdr.delete(); expPix.delete(); gotHdr.delete(); gotPix.delete();
      pixCyc.delete(); irqAt.delete();
      mode = m; stallPct = pct; srcIdx = 0; doneCount = 0; stallInj = 0;
      frame_start = 1'b1;
   endtask

   task automatic runFrame(input int m, input int pct);
      int n = 0;
      startFrame(m, pct);
      while (doneCount == 0 && n < 3000) begin
         applyStimulus();
         n++;
      end
      repeat (4) applyStimulus();
   endtask

   task automatic test_reset();
      rst = 1'b1; frame_start = 1'b0; interrupt = 1'b0;
      bus.s_valid = 1'b0; bus.s_data = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.s_ready, bus.hdr_valid, bus.inPixelValid, busy, done, irq_overrun} !== 6'b0)
         $display("[TB] FAIL reset_flags: got %b required 000000",
                  {bus.s_ready, bus.hdr_valid, bus.inPixelValid, busy, done, irq_overrun});
      else passed++;
      checks++;
      if ({bus.hdr_data, bus.inPixel} !== 16'h0)
         $display("[TB] FAIL reset_data: got %h required 0000", {bus.hdr_data, bus.inPixel});
      else passed++;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) $display("[TB] FAIL idle_busy: got %b required 0", busy);
      else passed++;
   endtask

   task automatic test_full_frame();
      logic [7:0] g, e;
      runFrame(0, 0);
      checks++;
      if (gotHdr.size() !== HB) $display("[TB] FAIL ff_hdr_count: got %0d required %0d", gotHdr.size(), HB);
      else passed++;
      checks++;
      if (gotPix.size() !== PIX_TOTAL) $display("[TB] FAIL ff_pix_count: got %0d required %0d", gotPix.size(), PIX_TOTAL);
      else passed++;
      while (gotHdr.size() > 0 && expHdr.size() > 0) begin
         g = gotHdr.pop_front(); e = expHdr.pop_front(); checks++;
         if (g !== e) $display("[TB] FAIL ff_hdr_data: got %h required %h", g, e);
         else passed++;
      end
      while (gotPix.size() > 0 && expPix.size() > 0) begin
         g = gotPix.pop_front(); e = expPix.pop_front(); checks++;
         if (g !== e) $display("[TB] FAIL ff_pix_data: got %h required %h", g, e);
         else passed++;
      end
      checks++;
      if (doneCount !== 1) $display("[TB] FAIL ff_done_pulses: got %0d required 1", doneCount);
      else passed++;
      checks++;
      if ({busy, irq_overrun} !== 2'b00) $display("[TB] FAIL ff_end_flags: got %b required 00", {busy, irq_overrun});
      else passed++;
   endtask

   task automatic test_random_stall();
      logic [7:0] g, e;
      runFrame(0, 30);
      checks++;
      if (gotPix.size() !== PIX_TOTAL || gotHdr.size() !== HB)
         $display("[TB] FAIL st_counts: got %0d/%0d required %0d/%0d", gotHdr.size(), gotPix.size(), HB, PIX_TOTAL);
      else passed++;
      while (gotPix.size() > 0 && expPix.size() > 0) begin
         g = gotPix.pop_front(); e = expPix.pop_front(); checks++;
         if (g !== e) $display("[TB] FAIL st_pix_data: got %h required %h", g, e);
         else passed++;
      end
      checks++;
      if (doneCount !== 1) $display("[TB] FAIL st_done_pulses: got %0d required 1", doneCount);
      else passed++;
`ifdef FEEDER_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'(stallInj)) $display("[TB] FAIL st_stall_cnt: got %0d required %0d", stall_cnt, stallInj);
      else passed++;
`endif
   endtask

   task automatic test_irq_on_last_pixel();
      runFrame(1, 0);
      checks++;
      if (gotPix.size() !== PIX_TOTAL) $display("[TB] FAIL lp_pix_count: got %0d required %0d", gotPix.size(), PIX_TOTAL);
      else passed++;
      if (pixCyc.size() >= 49) begin
         checks++;
         if (pixCyc[40] - pixCyc[39] !== 2) $display("[TB] FAIL lp_gap_line5: got %0d required 2", pixCyc[40] - pixCyc[39]);
         else passed++;
         checks++;
         if (pixCyc[48] - pixCyc[47] !== 2) $display("[TB] FAIL lp_gap_pad: got %0d required 2", pixCyc[48] - pixCyc[47]);
         else passed++;
      end
      checks++;
      if (irq_overrun !== 1'b0) $display("[TB] FAIL lp_overrun: got %b required 0", irq_overrun);
      else passed++;
   endtask

   task automatic test_overrun();
      logic [7:0] g, e;
      startFrame(2, 0);
      repeat (200) applyStimulus();
      checks++;
      if (gotPix.size() !== H * W) $display("[TB] FAIL ov_pix_count: got %0d required %0d", gotPix.size(), H * W);
      else passed++;
      while (gotPix.size() > 0 && expPix.size() > 0) begin
         g = gotPix.pop_front(); e = expPix.pop_front(); checks++;
         if (g !== e) $display("[TB] FAIL ov_pix_data: got %h required %h", g, e);
         else passed++;
      end
      checks++;
      if ({irq_overrun, busy, done} !== 3'b110 || doneCount !== 0)
         $display("[TB] FAIL ov_flags: got %b/%0d required 110/0", {irq_overrun, busy, done}, doneCount);
      else passed++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({irq_overrun, busy} !== 2'b00) $display("[TB] FAIL ov_reset_clear: got %b required 00", {irq_overrun, busy});
      else passed++;
   endtask

   task automatic test_reset_mid_line();
      int n = 0;
      logic [7:0] g, e;
      startFrame(0, 0);
      while (srcIdx != HB + P * W + 3 && n < 500) begin
         applyStimulus();
         n++;
      end
      checks++;
      if (srcIdx !== HB + P * W + 3) $display("[TB] FAIL rm_reach_line: got %0d required %0d", srcIdx, HB + P * W + 3);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.s_ready, bus.hdr_valid, bus.inPixelValid, busy, done, irq_overrun, bus.hdr_data, bus.inPixel} !== 22'h0)
         $display("[TB] FAIL rm_outputs: got %h required 0",
                  {bus.s_ready, bus.hdr_valid, bus.inPixelValid, busy, done, irq_overrun, bus.hdr_data, bus.inPixel});
      else passed++;
      rst = 1'b0;
      @(negedge clk);
      runFrame(0, 0);
      checks++;
      if (gotPix.size() !== PIX_TOTAL || doneCount !== 1)
         $display("[TB] FAIL rm_rerun: got %0d pixels %0d done required %0d pixels 1 done", gotPix.size(), doneCount, PIX_TOTAL);
      else passed++;
      while (gotPix.size() > 0 && expPix.size() > 0) begin
         g = gotPix.pop_front(); e = expPix.pop_front(); checks++;
         if (g !== e) $display("[TB] FAIL rm_pix_data: got %h required %h", g, e);
         else passed++;
      end
   endtask

   task automatic test_ignored_starts();
      logic [7:0] g, e;
      runFrame(3, 0);
      checks++;
      if (gotHdr.size() !== HB || gotPix.size() !== PIX_TOTAL || doneCount !== 1)
         $display("[TB] FAIL is_counts: got %0d/%0d/%0d required %0d/%0d/1", gotHdr.size(), gotPix.size(), doneCount, HB, PIX_TOTAL);
      else passed++;
      while (gotHdr.size() > 0 && expHdr.size() > 0) begin
         g = gotHdr.pop_front(); e = expHdr.pop_front(); checks++;
         if (g !== e) $display("[TB] FAIL is_hdr_data: got %h required %h", g, e);
         else passed++;
      end
      while (gotPix.size() > 0 && expPix.size() > 0) begin
         g = gotPix.pop_front(); e = expPix.pop_front(); checks++;
         if (g !== e) $display("[TB] FAIL is_pix_data: got %h required %h", g, e);
         else passed++;
      end
      checks++;
      if ({busy, irq_overrun} !== 2'b00) $display("[TB] FAIL is_end_flags: got %b required 00", {busy, irq_overrun});
      else passed++;
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_random_stall();
      test_irq_on_last_pixel();
      test_overrun();
      test_reset_mid_line();
      test_ignored_starts();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
